// File: rtl/mdr_pkg.sv
// Shared types for the MDR multiply/divide/square-root datapath.
// Pure declarations: no logic, no latency.
// No flow control of its own; users decide how handshakes are sequenced.
package mdr_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0]   data_bus_n;
    typedef logic [2*DATA_W-1:0] data_bus_2n;

    // Operation selector; NONE loads operands and completes with no iterations
    typedef enum logic [1:0] {
        MULT = 2'd0,
        DIV  = 2'd1,
        SQRT = 2'd2,
        NONE = 2'd3
    } op_bus;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdr_state_e;

    // Number of datapath iterations an operation needs for a given operand width
    function automatic int unsigned iter_count(op_bus op, int unsigned dw);
        case (op)
            MULT, DIV: return dw;
            SQRT:      return dw / 2;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/mdr_shift_unit.sv
// Per-iteration shift of the MDR operands for the selected operation.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the result is committed.
module mdr_shift_unit
    import mdr_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [1:0]      mode,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            aux,
    input  logic [2*DW-1:0] d,
    output logic [DW-1:0]   a_nxt,
    output logic [DW-1:0]   b_nxt,
    output logic            aux_nxt,
    output logic [2*DW-1:0] d_nxt
);

    // Mode-dependent shift; anything not shifted by the mode passes through
    always_comb begin
        a_nxt   = a;
        b_nxt   = b;
        aux_nxt = aux;
        d_nxt   = d;
        case (op_bus'(mode))
            MULT: begin
                // arithmetic right shift of {A,B,aux}: sign of A is replicated
                a_nxt   = {a[DW-1], a[DW-1:1]};
                b_nxt   = {a[0], b[DW-1:1]};
                aux_nxt = b[0];
            end
            DIV: begin
                // left shift of {A,B}, zero into the quotient LSB
                a_nxt = {a[DW-2:0], b[DW-1]};
                b_nxt = {b[DW-2:0], 1'b0};
            end
            SQRT: begin
                // left shift of {A,D} by two: next radicand bit pair enters A
                a_nxt = {a[DW-3:0], d[2*DW-1 -: 2]};
                d_nxt = {d[2*DW-3:0], 2'b00};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mdr_operand_bank.sv
// Operand registers and iteration sequencer for one MDR multiply/divide/sqrt.
// Load visible 1 cycle after acceptance; each step 1 cycle; done 1 cycle after last step.
// load_ready only in IDLE; loads outside IDLE are dropped; result held until result_ack.
module mdr_operand_bank
    import mdr_pkg::*;
#(
    parameter int DW = 16,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      op_sel,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [DW-1:0]   op_a_in,
    input  logic [DW-1:0]   op_b_in,
    input  logic            aux_in,
    input  logic [2*DW-1:0] d_in,
    input  logic            step_en,
    input  logic            wb_en,
    input  logic [DW-1:0]   wb_a,
    input  logic            wb_b0,
    input  logic            result_ack,
    input  logic            abort,
    output logic [DW-1:0]   op_a_out,
    output logic [DW-1:0]   op_b_out,
    output logic            aux_out,
    output logic [2*DW-1:0] d_out,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   iter_cnt
);

    mdr_state_e      state_q, state_d;
    op_bus           mode_q, mode_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            aux_q, aux_d;
    logic [2*DW-1:0] d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    op_bus           op_in;
    logic [DW-1:0]   a_src, b_src;
    logic [DW-1:0]   sh_a, sh_b;
    logic            sh_aux;
    logic [2*DW-1:0] sh_d;

    assign op_in = op_bus'(op_sel);

    // Writeback overlays the registered values before the shift sees them
    assign a_src = wb_en ? wb_a : a_q;
    assign b_src = wb_en ? {b_q[DW-1:1], wb_b0} : b_q;

    mdr_shift_unit #(.DW(DW)) u_shift (
        .mode    (mode_q),
        .a       (a_src),
        .b       (b_src),
        .aux     (aux_q),
        .d       (d_q),
        .a_nxt   (sh_a),
        .b_nxt   (sh_b),
        .aux_nxt (sh_aux),
        .d_nxt   (sh_d)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and next register contents; every path into IDLE clears the bank
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        aux_d   = aux_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            mode_d  = MULT;
            a_d     = '0;
            b_d     = '0;
            aux_d   = 1'b0;
            d_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        mode_d  = op_in;
                        a_d     = op_a_in;
                        b_d     = op_b_in;
                        aux_d   = aux_in;
                        d_d     = d_in;
                        cnt_d   = CW'(iter_count(op_in, DW));
                        state_d = (op_in == NONE) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (step_en) begin
                        a_d   = sh_a;
                        b_d   = sh_b;
                        aux_d = sh_aux;
                        d_d   = sh_d;
                        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                        if (cnt_q <= CW'(1)) state_d = DONE;
                    end else if (wb_en) begin
                        a_d = a_src;
                        b_d = b_src;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state_d = IDLE;
                        mode_d  = MULT;
                        a_d     = '0;
                        b_d     = '0;
                        aux_d   = 1'b0;
                        d_d     = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    mode_d  = MULT;
                    a_d     = '0;
                    b_d     = '0;
                    aux_d   = 1'b0;
                    d_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Operand and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MULT;
            a_q    <= '0;
            b_q    <= '0;
            aux_q  <= 1'b0;
            d_q    <= '0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            a_q    <= a_d;
            b_q    <= b_d;
            aux_q  <= aux_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
        end
    end

    assign op_a_out   = a_q;
    assign op_b_out   = b_q;
    assign aux_out    = aux_q;
    assign d_out      = d_q;
    assign iter_cnt   = cnt_q;
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mdr_operand_bank.sv
// Randomized plus directed bench for mdr_operand_bank at DW=8.
// Driver pushes expected post-edge snapshots; monitor compares at each falling edge.
// Reference model works on concatenated operand words with plain shifts.
module tb_mdr_operand_bank;
    import mdr_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      op_sel;
    logic            load_valid, load_ready;
    logic [DW-1:0]   op_a_in, op_b_in, wb_a;
    logic            aux_in, wb_b0;
    logic [2*DW-1:0] d_in;
    logic            step_en, wb_en, result_ack, abort;
    logic [DW-1:0]   op_a_out, op_b_out;
    logic            aux_out;
    logic [2*DW-1:0] d_out;
    logic            busy, done;
    logic [CW-1:0]   iter_cnt;

    int tests = 0;
    int fails = 0;

    mdr_operand_bank #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .op_sel(op_sel), .load_valid(load_valid),
        .load_ready(load_ready), .op_a_in(op_a_in), .op_b_in(op_b_in),
        .aux_in(aux_in), .d_in(d_in), .step_en(step_en), .wb_en(wb_en),
        .wb_a(wb_a), .wb_b0(wb_b0), .result_ack(result_ack), .abort(abort),
        .op_a_out(op_a_out), .op_b_out(op_b_out), .aux_out(aux_out),
        .d_out(d_out), .busy(busy), .done(done), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            m_st;    // 0 idle, 1 running, 2 finished
    int            m_mode;
    logic [DW-1:0] m_a, m_b;
    logic          m_aux;
    logic [15:0]   m_d;
    int            m_cnt;

    logic [39:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_st = 0; m_mode = 0; m_a = '0; m_b = '0; m_aux = 1'b0; m_d = '0; m_cnt = 0;
    endtask

    function automatic logic [39:0] model_snap();
        return {m_a, m_b, m_aux, m_d, 4'(m_cnt), m_st == 1, m_st == 2, m_st == 0};
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic lv, input logic [7:0] a,
                               input logic [7:0] b, input logic ax, input logic [15:0] d,
                               input logic se, input logic we, input logic [7:0] wa,
                               input logic wb0, input logic ack, input logic ab);
        logic [7:0]         ap, bp;
        logic signed [16:0] mv;
        logic [15:0]        dv;
        logic [23:0]        sv;
        if (ab) begin
            model_clear();
        end else if (m_st == 0) begin
            if (lv) begin
                m_mode = op; m_a = a; m_b = b; m_aux = ax; m_d = d;
                m_cnt = (op == SQRT) ? DW / 2 : (op == NONE) ? 0 : DW;
                m_st  = (op == NONE) ? 2 : 1;
            end
        end else if (m_st == 1) begin
            ap = we ? wa : m_a;
            bp = we ? {m_b[7:1], wb0} : m_b;
            if (se) begin
                if (m_mode == MULT) begin
                    mv = $signed({ap, bp, m_aux}) >>> 1;
                    {m_a, m_b, m_aux} = mv;
                end else if (m_mode == DIV) begin
                    dv = {ap, bp} << 1;
                    {m_a, m_b} = dv;
                end else begin
                    sv = {ap, m_d} << 2;
                    {m_a, m_d} = sv;
                    m_b = bp;
                end
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_st = 2;
            end else if (we) begin
                m_a = ap; m_b = bp;
            end
        end else if (ack) begin
            model_clear();
        end
    endtask

    // One clock of stimulus: inputs change just after the falling edge
    task automatic drive(input logic [1:0] op, input logic lv, input logic [7:0] a,
                         input logic [7:0] b, input logic ax, input logic [15:0] d,
                         input logic se, input logic we, input logic [7:0] wa,
                         input logic wb0, input logic ack, input logic ab);
        @(negedge clk); #1;
        op_sel = op; load_valid = lv; op_a_in = a; op_b_in = b; aux_in = ax; d_in = d;
        step_en = se; wb_en = we; wb_a = wa; wb_b0 = wb0; result_ack = ack; abort = ab;
        model_apply(op, lv, a, b, ax, d, se, we, wa, wb0, ack, ab);
        exp_q.push_back(model_snap());
    endtask

    task automatic load(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ax, input logic [15:0] d);
        drive(op, 1'b1, a, b, ax, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic we, input logic [7:0] wa, input logic wb0);
        drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, we, wa, wb0, 1'b0, 1'b0);
    endtask

    task automatic ack_cycle();
        drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic abort_cycle(input logic se);
        drive(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, se, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Wait until just after the edge that commits the last driven cycle
    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        op_sel = 2'd0; load_valid = 1'b0; op_a_in = '0; op_b_in = '0; aux_in = 1'b0;
        d_in = '0; step_en = 1'b0; wb_en = 1'b0; wb_a = '0; wb_b0 = 1'b0;
        result_ack = 1'b0; abort = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", {op_a_out, op_b_out, aux_out, d_out, iter_cnt, busy, done, load_ready}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        model_clear();
        rst = 1'b1;
        #12;
        chk("reset_ready", load_ready, 1'b1);
        chk("reset_busy_done", {busy, done}, 2'b00);
        chk("reset_regs", {op_a_out, op_b_out, aux_out, d_out, iter_cnt}, '0);
        @(negedge clk); #1;
        rst = 1'b0;

        // MULT single step
        load(MULT, 8'h81, 8'h02, 1'b1, 16'h0000);
        step(1'b0, 8'h00, 1'b0);
        settle();
        chk("mult_a", op_a_out, 8'hC0);
        chk("mult_b", op_b_out, 8'h81);
        chk("mult_aux", aux_out, 1'b0);
        chk("mult_cnt_busy", {iter_cnt, busy}, {4'd7, 1'b1});
        abort_cycle(1'b0);

        // DIV: plain step then step with writeback
        load(DIV, 8'h00, 8'h85, 1'b0, 16'h0000);
        step(1'b0, 8'h00, 1'b0);
        settle();
        chk("div_step1", {op_a_out, op_b_out, iter_cnt}, {8'h01, 8'h0A, 4'd7});
        step(1'b1, 8'h01, 1'b1);
        settle();
        chk("div_step2_wb", {op_a_out, op_b_out}, {8'h02, 8'h16});
        abort_cycle(1'b0);

        // SQRT to completion, then acknowledge
        load(SQRT, 8'h00, 8'h00, 1'b0, 16'hC400);
        settle();
        chk("sqrt_load_cnt", iter_cnt, 4'd4);
        step(1'b0, 8'h00, 1'b0);
        settle();
        chk("sqrt_step1", {op_a_out, d_out, iter_cnt}, {8'h03, 16'h1000, 4'd3});
        repeat (3) step(1'b0, 8'h00, 1'b0);
        settle();
        chk("sqrt_done", {done, busy, iter_cnt}, {1'b1, 1'b0, 4'd0});
        ack_cycle();
        settle();
        chk("ack_clears", {op_a_out, op_b_out, aux_out, d_out, iter_cnt}, '0);
        chk("ack_ready", {load_ready, done}, 2'b10);

        // NONE passes straight through to done; step in done is ignored
        load(NONE, 8'h12, 8'h34, 1'b1, 16'h5678);
        settle();
        chk("none_done", {done, op_a_out, op_b_out, d_out}, {1'b1, 8'h12, 8'h34, 16'h5678});
        step(1'b1, 8'hFF, 1'b1);
        settle();
        chk("done_step_ignored", {op_a_out, op_b_out, aux_out}, {8'h12, 8'h34, 1'b1});
        // ack with load_valid high: no load accepted this cycle
        drive(MULT, 1'b1, 8'h55, 8'h66, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("ack_no_load", {load_ready, op_a_out}, {1'b1, 8'h00});

        // load_valid in RUN is ignored; abort beats step_en
        load(MULT, 8'h3C, 8'hA5, 1'b0, 16'h0000);
        load(DIV, 8'hFF, 8'hFF, 1'b1, 16'hFFFF);
        settle();
        chk("run_load_ignored", {op_a_out, op_b_out, iter_cnt, busy}, {8'h3C, 8'hA5, 4'd8, 1'b1});
        abort_cycle(1'b1);
        settle();
        chk("abort_clears", {op_a_out, op_b_out, aux_out, d_out, iter_cnt}, '0);
        chk("abort_idle", {load_ready, busy, done}, 3'b100);

        // asynchronous reset between clock edges mid-operation
        load(DIV, 8'h5A, 8'hC3, 1'b1, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #1;
        chk("async_rst_regs", {op_a_out, op_b_out, aux_out, d_out, iter_cnt, busy}, '0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", load_ready, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
                  8'($urandom), 8'($urandom), 1'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                  8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) < 2));
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdr_operand_bank.md
Name: mdr_operand_bank

Overview:
- Parametrised, stateful successor to the MDR operand registers.
- Holds the A, B, aux and D operands for one multiply, divide or square-root operation.
- Performs the per-iteration shift inside the registers rather than on the output path.
- Counts the iterations, and uses load and result handshakes to sequence the shared MDR datapath.

Parameters:
- DW, 16: operand width. Must be even and at least 4. D is 2*DW wide.
- CW, $clog2(DW+1): iteration-counter width. Localparam, derived from DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_sel  in  2  mdr_pkg op_bus: MULT, DIV, SQRT, NONE. Sampled only on load.
- load_valid  in  1  load request.
- load_ready  out  1  high in IDLE only.
- op_a_in  in  DW  initial A.
- op_b_in  in  DW  initial B.
- aux_in  in  1  initial aux bit.
- d_in  in  2*DW  initial D (radicand or dividend extension).
- step_en  in  1  one datapath iteration strobe.
- wb_en  in  1  datapath writeback strobe.
- wb_a  in  DW  writeback value for A.
- wb_b0  in  1  writeback value for B bit 0 (quotient/root bit).
- result_ack  in  1  consumer accepts the result.
- abort  in  1  synchronous cancel.
- op_a_out  out  DW  registered A.
- op_b_out  out  DW  registered B.
- aux_out  out  1  registered aux.
- d_out  out  2*DW  registered D.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- iter_cnt  out  CW  remaining iterations.

Behaviour:
- Reset: all registers, outputs and iter_cnt go to 0. FSM goes to IDLE, so load_ready=1 and busy=done=0. Reset mid-operation discards the operation immediately.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs are forced to 0.
  - On load_valid (load_ready=1), capture all *_in values and latch op_sel into mode.
  - iter_cnt loads DW for MULT and DIV, DW/2 for SQRT, 0 for NONE.
  - Next state is RUN, or DONE for NONE.
  - Loaded values appear on the outputs the next cycle.
- RUN, on a step_en cycle:
  - Source values: A' = wb_en ? wb_a : A. B' = B with bit 0 replaced by wb_b0 when wb_en. aux and D are unchanged by writeback.
  - The mode shift is then applied to the source values.
  - MULT: arithmetic right shift of {A',B',aux} by 1. A<={A'[DW-1],A'[DW-1:1]}, B<={A'[0],B'[DW-1:1]}, aux<=B'[0]. D held.
  - DIV: left shift of {A',B'} by 1. A<={A'[DW-2:0],B'[DW-1]}, B<={B'[DW-2:0],0}. aux and D held.
  - SQRT: left shift of {A',D} by 2. A<={A'[DW-3:0],D[2DW-1:2DW-2]}, D<={D[2DW-3:0],2'b00}. B<=B'. aux held.
  - iter_cnt decrements. If iter_cnt was 1, next state is DONE.
- RUN, wb_en without step_en: writeback only, no shift, no count.
- RUN, neither strobe: all registers hold.
- DONE:
  - Outputs hold the final values and done=1.
  - result_ack moves to IDLE, where outputs go to 0 the next cycle.
  - step_en and wb_en are ignored.
- abort (any state) moves to IDLE and clears all registers next cycle. abort has priority over step_en, wb_en, load_valid and result_ack.
- load_valid outside IDLE is ignored and does not queue. A result_ack in DONE with load_valid high accepts no load that cycle, so loads are back-to-back with a one-cycle gap.
- Latency: load to first valid output is 1 cycle. Each step is 1 cycle. Last step to done is 1 cycle.
- iter_cnt never wraps. It stays at 0 in DONE and IDLE.

Decomposition:
- mdr_pkg gains:
  - op_bus encoding with NONE added.
  - mdr_state_e (IDLE, RUN, DONE).
  - a function iter_count(op_bus, DW).
- data_bus_n and data_bus_2n stay in the package. This block uses its own DW-parametrised logic vectors.
- One natural sub-module, mdr_shift_unit. It is purely combinational: it takes mode, A', B', aux and D and returns the next A, B, aux and D. The FSM and registers stay in mdr_operand_bank.

Test Plan (DW=8):
- MULT: load A=0x81, B=0x02, aux=1, then one step_en with wb_en=0 -> A=0xC0, B=0x81, aux=0, iter_cnt 8->7, busy=1.
- DIV: load A=0x00, B=0x85, then step -> A=0x01, B=0x0A, iter_cnt=7. Then step with wb_en=1, wb_a=0x01, wb_b0=1 -> A=0x02, B=0x16.
- SQRT: load A=0, D=0xC400, then step -> A=0x03, D=0x1000, iter_cnt 4->3. After 4 steps -> done=1, busy=0. result_ack -> next cycle all outputs 0, load_ready=1.
- Handshake:
  - NONE load -> done next cycle with pass-through values.
  - load_valid asserted in RUN is ignored.
  - step_en in DONE leaves values unchanged.
- abort and step_en together in RUN -> IDLE, outputs 0, iter_cnt=0.
- rst pulsed asynchronously mid-RUN (between clock edges) -> outputs 0 immediately, load_ready=1 after release.
